// File: rtl/plot_cmd_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : plot_cmd_sink
// Description : Sink for the (x, y, colour, plot) pixel-command stream.
//               Plot commands are buffered in a small FIFO and drained one
//               per cycle into a WIDTH x HEIGHT colour framebuffer RAM.
//               Includes a one-cycle-latency readback port and a bulk
//               clear sweep.
//               Optional macro PLOT_FWD_EN: readback also sees commands
//               still waiting in the FIFO and words already swept by an
//               in-progress clear.
// Revision    : 1.0 - initial release
// ============================================================================
module plot_cmd_sink #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 120,
  parameter int COLOUR_BITS  = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLEAR_COLOUR = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          plot,
  input  logic [7:0]                    x,
  input  logic [6:0]                    y,
  input  logic [COLOUR_BITS-1:0]        colour,
  output logic                          ready,
  input  logic                          rd_req,
  input  logic [7:0]                    rd_x,
  input  logic [6:0]                    rd_y,
  output logic                          rd_valid,
  output logic [COLOUR_BITS-1:0]        rd_colour,
  input  logic                          clear,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          dropped
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = 15;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int FW   = PW + 1;
  localparam logic [AW-1:0]          LAST_ADDR  = AW'(NPIX - 1);
  localparam logic [COLOUR_BITS-1:0] CLEAR_WORD = COLOUR_BITS'(CLEAR_COLOUR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t                   state;
  logic                     clear_pend;
  logic [AW-1:0]            clr_ptr;
  logic                     drop_flag;

  logic [AW-1:0]            fifo_addr [FIFO_DEPTH];
  logic [COLOUR_BITS-1:0]   fifo_col  [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [FW-1:0]            count;

  logic [COLOUR_BITS-1:0]   mem [NPIX];
  logic [COLOUR_BITS-1:0]   rd_ram;
  logic                     rd_valid_q;
  logic                     rd_ok_q;
  logic [COLOUR_BITS-1:0]   rd_data;

  logic                     cmd_in_range;
  logic [AW-1:0]            cmd_addr;
  logic                     rd_in_range;
  logic [AW-1:0]            rd_addr;
  logic [AW-1:0]            rd_idx;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [COLOUR_BITS-1:0]   wr_data;

  // Linear addresses are row-major; out-of-range coordinates never touch RAM.
  assign cmd_in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  assign cmd_addr     = AW'(32'(y) * WIDTH + 32'(x));
  assign rd_in_range  = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign rd_addr      = AW'(32'(rd_y) * WIDTH + 32'(rd_x));
  assign rd_idx       = rd_in_range ? rd_addr : '0;

  // No new commands while a clear is queued or running so the clear cannot
  // reorder against them.
  assign ready  = !reset && (count != FW'(FIFO_DEPTH)) && (state != S_CLEAR) && !clear_pend;
  assign accept = plot && ready;
  assign push   = accept && cmd_in_range;
  // A readback owns the RAM for the cycle, so drain and clear both stall.
  assign pop    = (state == S_DRAIN) && !rd_req && (count != '0);

  assign wr_en   = !reset && (pop || ((state == S_CLEAR) && !rd_req));
  assign wr_addr = (state == S_CLEAR) ? clr_ptr : fifo_addr[rd_ptr];
  assign wr_data = (state == S_CLEAR) ? CLEAR_WORD : fifo_col[rd_ptr];

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless outside the valid window.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_col[wr_ptr]  <= colour;
    end
  end

  // Control FSM: drain, pending clear, clear sweep and the sticky drop flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      clear_pend <= 1'b0;
      clr_ptr    <= '0;
      drop_flag  <= 1'b0;
    end else begin
      if (accept && !cmd_in_range) drop_flag <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_DRAIN;
            if (clear) clear_pend <= 1'b1;
          end else if (clear) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
          end
        end
        S_DRAIN: begin
          if (pop && (count == FW'(1)) && !push) begin
            if (clear_pend || clear) begin
              state   <= S_CLEAR;
              clr_ptr <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else if (clear) begin
            clear_pend <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (!rd_req) begin
            if (clr_ptr == LAST_ADDR) begin
              state      <= S_IDLE;
              clear_pend <= 1'b0;
              drop_flag  <= 1'b0;
            end else begin
              clr_ptr <= clr_ptr + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Framebuffer RAM: one write port, one synchronous read port.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_req) rd_ram <= mem[rd_idx];
  end

  // Readback handshake: valid exactly one cycle after the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      rd_ok_q    <= rd_req && rd_in_range;
    end
  end

`ifdef PLOT_FWD_EN
  logic                   fwd_hit;
  logic [COLOUR_BITS-1:0] fwd_col;
  logic                   swept;
  logic                   fwd_hit_q;
  logic [COLOUR_BITS-1:0] fwd_col_q;
  logic                   swept_q;

  // Newest matching FIFO entry wins: scan oldest to newest, last hit sticks.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_col = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((FW'(i) < count) && (fifo_addr[rd_ptr + PW'(i)] == rd_addr)) begin
        fwd_hit = 1'b1;
        fwd_col = fifo_col[rd_ptr + PW'(i)];
      end
    end
  end

  assign swept = (state == S_CLEAR) && (rd_addr < clr_ptr);

  // Capture the forwarding decision alongside the RAM read.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_hit_q <= 1'b0;
      fwd_col_q <= '0;
      swept_q   <= 1'b0;
    end else begin
      fwd_hit_q <= rd_req && rd_in_range && fwd_hit;
      fwd_col_q <= fwd_col;
      swept_q   <= rd_req && rd_in_range && swept;
    end
  end

  assign rd_data = fwd_hit_q ? fwd_col_q : (swept_q ? CLEAR_WORD : rd_ram);
`else
  assign rd_data = rd_ram;
`endif

  assign rd_valid  = rd_valid_q && !reset;
  assign rd_colour = (rd_ok_q && !reset) ? rd_data : '0;
  assign busy      = !reset && ((count != '0) || clear_pend || (state == S_CLEAR));
  assign fill      = reset ? '0 : count;
  assign dropped   = drop_flag && !reset;

endmodule
`default_nettype wire
